// File: rtl/core_amo_seq_pkg.sv
// Shared types for the A-extension sequencer: op codes, bus direction,
// reservation updates, ALU selects and FSM states.
package core_amo_seq_pkg;

    localparam int unsigned AMO_OP_W = 5;

    // Encodings follow the RISC-V funct5 field of the AMO opcode
    typedef enum logic [AMO_OP_W-1:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_e;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_dir_e;

    typedef enum logic [1:0] {
        RSV_NONE,
        RSV_SET,
        RSV_CLEAR
    } mem_rsv_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_MIN,
        ALU_MAX,
        ALU_MINU,
        ALU_MAXU,
        ALU_OB
    } alu_op_e;

    typedef enum logic [1:0] {
        AMO_IDLE,
        AMO_READ,
        AMO_WRITE,
        AMO_DONE
    } amo_state_e;

    localparam logic SC_SUCCESS = 1'b0;
    localparam logic SC_FAIL    = 1'b1;

    // LR/SC never reach the ALU; they fall through to pass-operand-B
    function automatic alu_op_e amo_to_alu(input amo_op_e op);
        case (op)
            AMO_ADD:  return ALU_ADD;
            AMO_XOR:  return ALU_XOR;
            AMO_OR:   return ALU_OR;
            AMO_AND:  return ALU_AND;
            AMO_MIN:  return ALU_MIN;
            AMO_MAX:  return ALU_MAX;
            AMO_MINU: return ALU_MINU;
            AMO_MAXU: return ALU_MAXU;
            default:  return ALU_OB;
        endcase
    endfunction

endpackage

// File: rtl/core_amo_alu.sv
// Combinational AMO operator: new = f(old, src) for the read-modify-write ops.
// Ties in min/max keep the old memory value.
module core_amo_alu
    import core_amo_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  amo_op_e         op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] result_c
);

    always_comb begin
        result_c = old;
        case (amo_to_alu(op))
            ALU_ADD:  result_c = old + src;
            ALU_XOR:  result_c = old ^ src;
            ALU_OR:   result_c = old | src;
            ALU_AND:  result_c = old & src;
            ALU_MIN:  if ($signed(src) < $signed(old)) result_c = src;
            ALU_MAX:  if ($signed(src) > $signed(old)) result_c = src;
            ALU_MINU: if (src < old) result_c = src;
            ALU_MAXU: if (src > old) result_c = src;
            ALU_OB:   result_c = src;
            default:  result_c = old;
        endcase
    end

endmodule

// File: rtl/core_amo_seq.sv
// LR/SC/AMO sequencer: bus read, op, conditional write, result return; owns the
// hart's load reservation. Define CORE_AMO_TIMEOUT_EN to enable the bus watchdog.
module core_amo_seq
    import core_amo_seq_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned RSV_GRAN_LOG2  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  amo_op_e         amo_op,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] src,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] rd_data,
    input  logic            rsv_clr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err
);

    localparam int unsigned TAG_W = XLEN - RSV_GRAN_LOG2;

    amo_state_e      state_q, state_d;
    amo_op_e         op_q, op_d;
    logic [XLEN-1:0] src_q, src_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            fault_q, fault_d;
    mem_dir_e        dir_q, dir_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    mem_rsv_e        rsv_op_c;
    logic            rsv_valid_q;
    logic [TAG_W-1:0] rsv_tag_q;
    logic            rsv_hit_c;
    logic            timeout_c;
    logic [XLEN-1:0] alu_res_c;

    core_amo_alu #(.XLEN(XLEN)) u_alu (
        .op       (op_q),
        .old      (mem_rdata),
        .src      (src_q),
        .result_c (alu_res_c)
    );

    // A kill arriving with the SC itself already defeats it
    assign rsv_hit_c = rsv_valid_q && !rsv_clr
                       && (rsv_tag_q == addr[XLEN-1:RSV_GRAN_LOG2]);

`ifdef CORE_AMO_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            new_req_c;

    assign new_req_c = (state_d != state_q)
                       && ((state_d == AMO_READ) || (state_d == AMO_WRITE));

    always_ff @(posedge clk) begin
        if (rst || new_req_c) begin
            wd_cnt_q <= '0;
        end else if (mem_req && !mem_ready) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end
    end

    assign timeout_c = mem_req && !mem_ready
                       && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AMO_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, command capture and result bookkeeping
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        tag_d    = tag_q;
        result_d = result_q;
        fault_d  = fault_q;
        dir_d    = dir_q;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;
        rsv_op_c = RSV_NONE;
        case (state_q)
            AMO_IDLE: begin
                if (start) begin
                    op_d     = amo_op;
                    src_d    = src;
                    tag_d    = addr[XLEN-1:RSV_GRAN_LOG2];
                    maddr_d  = {addr[XLEN-1:2], 2'b00};
                    dir_d    = MEM_READ;
                    fault_d  = 1'b0;
                    result_d = '0;
                    if (addr[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = AMO_DONE;
                    end else if (amo_op == AMO_SC) begin
                        rsv_op_c = RSV_CLEAR;
                        if (rsv_hit_c) begin
                            dir_d    = MEM_WRITE;
                            wdata_d  = src;
                            result_d = XLEN'(SC_SUCCESS);
                            state_d  = AMO_WRITE;
                        end else begin
                            result_d = XLEN'(SC_FAIL);
                            state_d  = AMO_DONE;
                        end
                    end else begin
                        state_d = AMO_READ;
                    end
                end
            end
            AMO_READ: begin
                if (timeout_c) begin
                    fault_d  = 1'b1;
                    rsv_op_c = RSV_CLEAR;
                    state_d  = AMO_DONE;
                end else if (mem_ready) begin
                    if (mem_err) begin
                        fault_d = 1'b1;
                        state_d = AMO_DONE;
                    end else if (op_q == AMO_LR) begin
                        result_d = mem_rdata;
                        rsv_op_c = RSV_SET;
                        state_d  = AMO_DONE;
                    end else begin
                        result_d = mem_rdata;
                        wdata_d  = alu_res_c;
                        dir_d    = MEM_WRITE;
                        state_d  = AMO_WRITE;
                    end
                end
            end
            AMO_WRITE: begin
                if (timeout_c) begin
                    fault_d  = 1'b1;
                    rsv_op_c = RSV_CLEAR;
                    state_d  = AMO_DONE;
                end else if (mem_ready) begin
                    if (mem_err) fault_d = 1'b1;
                    state_d = AMO_DONE;
                end
            end
            AMO_DONE: begin
                dir_d   = MEM_READ;
                state_d = AMO_IDLE;
            end
            default: state_d = AMO_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= AMO_ADD;
            src_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
            dir_q    <= MEM_READ;
            maddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            op_q     <= op_d;
            src_q    <= src_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            dir_q    <= dir_d;
            maddr_q  <= maddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // External kill has priority over an LR setting the reservation
    always_ff @(posedge clk) begin
        if (rst || rsv_clr) begin
            rsv_valid_q <= 1'b0;
            rsv_tag_q   <= rst ? '0 : rsv_tag_q;
        end else begin
            case (rsv_op_c)
                RSV_SET: begin
                    rsv_valid_q <= 1'b1;
                    rsv_tag_q   <= tag_q;
                end
                RSV_CLEAR: rsv_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Registered status; rd_data/err load only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rd_data <= '0;
            mem_req <= 1'b0;
        end else begin
            busy    <= (state_d != AMO_IDLE);
            done    <= (state_d == AMO_DONE);
            mem_req <= (state_d == AMO_READ) || (state_d == AMO_WRITE);
            if ((state_d == AMO_DONE) && (state_q != AMO_DONE)) begin
                rd_data <= result_d;
                err     <= fault_d;
            end
        end
    end

    assign mem_we    = (dir_q == MEM_WRITE);
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_core_amo_seq.sv
// Directed bench for core_amo_seq with a word memory model, wait states and
// error injection.
module tb_core_amo_seq;
    import core_amo_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    amo_op_e     amo_op;
    logic [31:0] addr, src;
    logic        busy, done, err;
    logic [31:0] rd_data;
    logic        rsv_clr;
    logic        mem_req, mem_we, mem_ready, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    core_amo_seq dut (
        .clk(clk), .rst(rst), .start(start), .amo_op(amo_op), .addr(addr), .src(src),
        .busy(busy), .done(done), .err(err), .rd_data(rd_data), .rsv_clr(rsv_clr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Bus model state
    logic [31:0] mem [0:1023];
    int unsigned wait_target;
    logic        stall_wr, err_rd;
    logic        poke_en;
    logic [9:0]  poke_idx;
    logic [31:0] poke_val;
    int unsigned wait_cnt   = 0;
    int unsigned req_cycles = 0;
    int unsigned n_rd = 0, n_wr = 0, unstable = 0;
    logic        p_pending = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0;

    assign mem_ready = mem_req && (wait_cnt >= wait_target) && !(stall_wr && mem_we);
    assign mem_rdata = mem[mem_addr[11:2]];
    assign mem_err   = err_rd && mem_req && !mem_we;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        if (mem_req && mem_ready && mem_we && !mem_err) mem[mem_addr[11:2]] <= mem_wdata;
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_req) req_cycles <= req_cycles + 1;
        if (mem_req && mem_ready) begin
            if (mem_we) n_wr <= n_wr + 1;
            else n_rd <= n_rd + 1;
        end
        if (p_pending && (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd))
            unstable <= unstable + 1;
        p_pending <= mem_req && !mem_ready;
        p_addr    <= mem_addr;
        p_we      <= mem_we;
        p_wd      <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        poke_en  = 1'b1;
        poke_idx = a[11:2];
        poke_val = d;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    // Issue one command; lat counts cycles from the start cycle to the done cycle
    task automatic run(input amo_op_e op, input logic [31:0] a, input logic [31:0] s,
                       input logic clr, output int lat, output int reqs);
        int unsigned rc0;
        bit got;
        rc0    = req_cycles;
        amo_op = op;
        addr   = a;
        src    = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rsv_clr = clr;
        got = done;
        lat = got ? 1 : -1;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            rsv_clr = 1'b0;
            if (done) begin
                got = 1'b1;
                lat = k + 1;
            end
        end
        rsv_clr = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
        reqs = int'(req_cycles - rc0);
    endtask

    initial begin
        int lat, reqs;
        int unsigned r0, w0, u0;
        bit reached;
        rst = 1'b1; start = 1'b0; rsv_clr = 1'b0; amo_op = AMO_ADD;
        addr = '0; src = '0; wait_target = 0; stall_wr = 1'b0; err_rd = 1'b0;
        poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // AMO_ADD zero-wait
        poke(32'h100, 32'd7);
        r0 = n_rd; w0 = n_wr;
        run(AMO_ADD, 32'h100, 32'd5, 1'b0, lat, reqs);
        chk("add_lat", 32'(lat), 32'd3);
        chk("add_rd", rd_data, 32'd7);
        chk("add_err", 32'(err), 32'd0);
        chk("add_mem", mem[32'h100 >> 2], 32'd12);
        chk("add_reads", n_rd - r0, 32'd1);
        chk("add_writes", n_wr - w0, 32'd1);

        // LR then SC success, then SC fail
        poke(32'h200, 32'hAA);
        run(AMO_LR, 32'h200, 32'd0, 1'b0, lat, reqs);
        chk("lr_lat", 32'(lat), 32'd2);
        chk("lr_rd", rd_data, 32'hAA);
        run(AMO_SC, 32'h200, 32'h55, 1'b0, lat, reqs);
        chk("sc_ok_lat", 32'(lat), 32'd2);
        chk("sc_ok_rd", rd_data, 32'd0);
        chk("sc_ok_mem", mem[32'h200 >> 2], 32'h55);
        run(AMO_SC, 32'h200, 32'h77, 1'b0, lat, reqs);
        chk("sc2_lat", 32'(lat), 32'd1);
        chk("sc2_rd", rd_data, 32'd1);
        chk("sc2_reqs", 32'(reqs), 32'd0);
        chk("sc2_mem", mem[32'h200 >> 2], 32'h55);

        // LR, idle kill, SC
        run(AMO_LR, 32'h200, 32'd0, 1'b0, lat, reqs);
        rsv_clr = 1'b1;
        @(posedge clk);
        #1;
        rsv_clr = 1'b0;
        run(AMO_SC, 32'h200, 32'h99, 1'b0, lat, reqs);
        chk("clr_sc_rd", rd_data, 32'd1);
        chk("clr_sc_reqs", 32'(reqs), 32'd0);

        // Kill coincident with the LR response
        run(AMO_LR, 32'h200, 32'd0, 1'b1, lat, reqs);
        chk("lrclr_rd", rd_data, 32'h55);
        run(AMO_SC, 32'h200, 32'h99, 1'b0, lat, reqs);
        chk("lrclr_sc_rd", rd_data, 32'd1);
        chk("lrclr_sc_reqs", 32'(reqs), 32'd0);
        chk("lrclr_mem", mem[32'h200 >> 2], 32'h55);

        // SC to a different granule fails
        run(AMO_LR, 32'h200, 32'd0, 1'b0, lat, reqs);
        run(AMO_SC, 32'h204, 32'h11, 1'b0, lat, reqs);
        chk("scgran_rd", rd_data, 32'd1);
        chk("scgran_reqs", 32'(reqs), 32'd0);

        // Signed vs unsigned min
        poke(32'h300, 32'hFFFF_FFFF);
        run(AMO_MIN, 32'h300, 32'd1, 1'b0, lat, reqs);
        chk("min_rd", rd_data, 32'hFFFF_FFFF);
        chk("min_mem", mem[32'h300 >> 2], 32'hFFFF_FFFF);
        poke(32'h304, 32'hFFFF_FFFF);
        run(AMO_MINU, 32'h304, 32'd1, 1'b0, lat, reqs);
        chk("minu_rd", rd_data, 32'hFFFF_FFFF);
        chk("minu_mem", mem[32'h304 >> 2], 32'd1);

        // XOR and SWAP
        poke(32'h310, 32'hF0F0_F0F0);
        run(AMO_XOR, 32'h310, 32'hFF00_FF00, 1'b0, lat, reqs);
        chk("xor_rd", rd_data, 32'hF0F0_F0F0);
        chk("xor_mem", mem[32'h310 >> 2], 32'h0FF0_0FF0);
        poke(32'h700, 32'h1234);
        run(AMO_SWAP, 32'h700, 32'hBEEF, 1'b0, lat, reqs);
        chk("swap_rd", rd_data, 32'h1234);
        chk("swap_mem", mem[32'h700 >> 2], 32'hBEEF);

        // Misaligned
        run(AMO_SWAP, 32'h102, 32'h5A5A, 1'b0, lat, reqs);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_reqs", 32'(reqs), 32'd0);
        chk("mis_mem", mem[32'h100 >> 2], 32'd12);

        // Bus error on read
        poke(32'h400, 32'h0F);
        err_rd = 1'b1;
        w0 = n_wr;
        run(AMO_OR, 32'h400, 32'hF0, 1'b0, lat, reqs);
        err_rd = 1'b0;
        chk("berr_err", 32'(err), 32'd1);
        chk("berr_lat", 32'(lat), 32'd2);
        chk("berr_writes", n_wr - w0, 32'd0);
        chk("berr_mem", mem[32'h400 >> 2], 32'h0F);

        // Three wait states on both phases
        poke(32'h500, 32'd5);
        wait_target = 3;
        u0 = unstable;
        run(AMO_MAX, 32'h500, 32'hFFFF_FFFD, 1'b0, lat, reqs);
        wait_target = 0;
        chk("ws_lat", 32'(lat), 32'd9);
        chk("ws_rd", rd_data, 32'd5);
        chk("ws_err", 32'(err), 32'd0);
        chk("ws_mem", mem[32'h500 >> 2], 32'd5);
        chk("ws_stable", unstable - u0, 32'd0);

        // Reset during a stalled write
        poke(32'h600, 32'd3);
        stall_wr = 1'b1;
        amo_op = AMO_ADD; addr = 32'h600; src = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            if (mem_req && mem_we) reached = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("rstw_reached", 32'(reached), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw_mem_req", 32'(mem_req), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        stall_wr = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_mem", mem[32'h600 >> 2], 32'd3);
        chk("rstw_done", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
